axi4_rd_burst_master: RTL and testbench
=======================================

# axi4_rd_burst_master

Parametrised AXI4 read-only master that turns single fetch requests into AXI4 INCR or WRAP bursts of 1..MAX_LEN beats. It sits between the instruction fetch / I-cache refill logic and the AXI4 interconnect, and generalises the single-beat instruction-fetch master. It returns each beat on a registered response port with backpressure and allows one outstanding transaction.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; power of two, 32..128
- ID_W, 4, ARID width
- ID_VAL, 0, constant ARID value
- MAX_LEN, 8, maximum beats per burst; power of two, 1..16
- BURST_WRAP, 0, 0 = INCR (ARBURST=2'b01), 1 = WRAP (ARBURST=2'b10)
- ACLK  in  1  clock; all logic on the rising edge
- ARESETn  in  1  reset, synchronous, active-low
- req_valid  in  1  fetch request
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  ADDR_W  byte address of the first beat
- req_len  in  $clog2(MAX_LEN) (min 1)  beats-1
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  consumer accepts the beat
- rsp_data  out  DATA_W  beat data
- rsp_last  out  1  final beat of the burst
- AR channel out: ARVALID, ARADDR[ADDR_W], ARID[ID_W], ARLEN[8], ARSIZE[3], ARBURST[2]; ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION tied to 0
- AR channel in: ARREADY
- R channel in: RVALID, RDATA[DATA_W], RRESP[2], RLAST, RID[ID_W] (RID ignored)
- R channel out: RREADY

## Operation
- FSM states IDLE, ADDR and DATA; reset state is IDLE.
- IDLE: req_ready=1 (combinational from state).
  - On the req handshake, latch the address with the low log2(DATA_W/8) bits cleared, and latch len.
  - Set ARVALID=1 and go to ADDR.
- ADDR: ARVALID, ARADDR and ARLEN stay stable until ARREADY.
  - On ARVALID && ARREADY: ARVALID←0, beat counter←0, go to DATA.
- DATA: RREADY = !rsp_valid || rsp_ready (combinational).
  - On RVALID && RREADY: rsp_data←RDATA, rsp_valid←1, rsp_last←RLAST, counter++.
  - If RLAST was accepted, go to IDLE.
- rsp_valid clears on rsp_ready when no new beat is captured in the same cycle. Capture and drain in the same cycle keeps rsp_valid=1 with the new data.
- Fixed field values:
  - ARSIZE=log2(DATA_W/8).
  - ARLEN={zero-extend req_len}.
  - ARID=ID_VAL.
- In WRAP mode req_len must be 1, 3, 7 or 15; other values are a caller error with undefined behaviour.
- RLAST alone terminates the burst; the counter is only checked under the macro.
- Reset mid-burst abandons the transaction. The interconnect shares ARESETn, so no drain is needed.

## Timing
- Reset values: ARVALID=0, RREADY=0, req_ready=0 during reset, rsp_valid=0, rsp_last=0, rsp_data=0, ARADDR=0, ARLEN=0.
- Request accepted in cycle 0 → ARVALID=1 in cycle 1.
- ARREADY in cycle 1 → RREADY possible from cycle 2.
- RVALID in cycle 2 → rsp_valid in cycle 3. Minimum request-to-first-beat latency is 3 cycles.
- Throughput is 1 beat/cycle with rsp_ready held high.
- The next req_ready is asserted the cycle after RLAST is captured; a new AR may issue while the last beat is still in rsp.
- Beats that arrive in ADDR are never accepted (RREADY=0).

## Configuration
- AXI4_RD_ERR_EN defined:
  - Adds port rsp_err (out, 1, reset 0), valid with rsp_last.
  - rsp_err=1 if any beat had RRESP[1]=1 (SLVERR/DECERR), or if RLAST arrived when counter≠len, or if counter reached len without RLAST.
  - In the no-RLAST case the final beat is still terminated on RLAST.
- AXI4_RD_ERR_EN not defined: no rsp_err port; RRESP is ignored.

## Test plan
- Single beat, len=0, addr 0x1000_0004, ARREADY/RVALID immediate → ARLEN=0, ARSIZE=2, rsp_data=RDATA at cycle 3, rsp_last=1, back in IDLE.
- INCR burst, len=7, addr 0x2000_0003 → ARADDR=0x2000_0000, ARLEN=7, 8 beats in order, rsp_last only on beat 8.
- rsp_ready toggled 1,0,0,1 during a 4-beat burst → RREADY low while stalled, no beat lost or duplicated, data order preserved.
- ARREADY delayed 5 cycles → ARVALID/ARADDR constant for all 5 cycles; RVALID asserted early in ADDR is not accepted.
- BURST_WRAP=1, len=3, addr 0x8 → ARBURST=2'b10; data for 0x8, 0xC, 0x0, 0x4 passed through unchanged.
- With AXI4_RD_ERR_EN: beat 2 RRESP=2'b10 → rsp_err=1 on the last beat; RLAST on beat 3 of len=7 → rsp_err=1.
- Reset mid-burst → all outputs return to reset values next cycle, then a new request completes normally.

Source files
------------

// File: rtl/axi4_rd_burst_master.sv
// -----------------------------------------------------------------------------
// axi4_rd_burst_master
//
// Read-only AXI4 master that turns one fetch request into a single INCR or
// WRAP burst of 1..MAX_LEN beats. Only one transaction is in flight at a time.
// Beats are returned through a one-entry registered response port that
// honours consumer backpressure.
//
// Optional feature macro: AXI4_RD_ERR_EN
//   When defined, the rsp_err output is added. It is meaningful on the
//   rsp_last beat and flags any of the following:
//     - a beat returned with a SLVERR or DECERR response
//     - RLAST arriving early
//     - the expected beat count passing without RLAST
//   When the macro is undefined, RRESP is ignored.
//
// Ports
//   ACLK, ARESETn        clock; synchronous active-low reset
//   req_*                fetch request (valid/ready, byte address, beats-1)
//   rsp_*                response beat (valid/ready, data, last[, err])
//   AR*                  AXI4 read address channel (master side)
//   R*, RREADY           AXI4 read data channel (RID is ignored)
// -----------------------------------------------------------------------------
module axi4_rd_burst_master #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int ID_W       = 4,
   parameter int ID_VAL     = 0,
   parameter int MAX_LEN    = 8,
   parameter int BURST_WRAP = 0
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   // fetch request
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [((MAX_LEN > 1) ? $clog2(MAX_LEN) : 1)-1:0] req_len,
   // response beats
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                rsp_last,
`ifdef AXI4_RD_ERR_EN
   output logic                rsp_err,
`endif
   // AXI4 AR channel
   output logic                ARVALID,
   input  logic                ARREADY,
   output logic [ADDR_W-1:0]   ARADDR,
   output logic [ID_W-1:0]     ARID,
   output logic [7:0]          ARLEN,
   output logic [2:0]          ARSIZE,
   output logic [1:0]          ARBURST,
   output logic                ARLOCK,
   output logic [3:0]          ARCACHE,
   output logic [2:0]          ARPROT,
   output logic [3:0]          ARQOS,
   output logic [3:0]          ARREGION,
   // AXI4 R channel
   input  logic                RVALID,
   input  logic [DATA_W-1:0]   RDATA,
   input  logic [1:0]          RRESP,
   input  logic                RLAST,
   input  logic [ID_W-1:0]     RID,
   output logic                RREADY
);

   localparam int LEN_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int OFF_W = $clog2(DATA_W / 8);
   // Clears the byte-within-beat offset so every burst starts on a beat boundary.
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(DATA_W / 8 - 1));

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                arvalid_q, arvalid_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_last_q, rsp_last_d;
   logic                rready;
   logic                r_hs;
`ifdef AXI4_RD_ERR_EN
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                err_acc_q, err_acc_d;
   logic                rsp_err_q, rsp_err_d;
   logic                beat_err;
`endif

   // ------------------------------------------------------------------
   // Next-state and combinational outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      arvalid_d   = arvalid_q;
      araddr_d    = araddr_q;
      len_d       = len_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_last_d  = rsp_last_q;
`ifdef AXI4_RD_ERR_EN
      cnt_d       = cnt_q;
      err_acc_d   = err_acc_q;
      rsp_err_d   = rsp_err_q;
      beat_err    = 1'b0;
`endif
      // req_ready is forced low while reset is asserted.
      req_ready   = (state_q == IDLE) && ARESETn;
      // Only take a beat when the response register is free or draining now.
      rready      = (state_q == DATA) && (!rsp_valid_q || rsp_ready);
      r_hs        = RVALID && rready;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               araddr_d  = req_addr & ADDR_MASK;
               len_d     = req_len;
               arvalid_d = 1'b1;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (ARREADY) begin
               arvalid_d = 1'b0;
               state_d   = DATA;
`ifdef AXI4_RD_ERR_EN
               cnt_d     = '0;
               err_acc_d = 1'b0;
`endif
            end
         end
         DATA: begin
            // RLAST alone ends the burst, even if the beat count disagrees.
            if (r_hs && RLAST) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The response register drains in any state, so a new AR can be issued
      // while the final beat of the previous burst is still waiting here.
      if (r_hs) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = RDATA;
         rsp_last_d  = RLAST;
`ifdef AXI4_RD_ERR_EN
         beat_err    = RRESP[1]
                     | ( RLAST && (cnt_q != len_q))
                     | (!RLAST && (cnt_q == len_q));
         err_acc_d   = err_acc_q | beat_err;
         cnt_d       = cnt_q + LEN_W'(1);
         rsp_err_d   = RLAST ? (err_acc_q | beat_err) : 1'b0;
`endif
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q     <= IDLE;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         len_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_last_q  <= 1'b0;
`ifdef AXI4_RD_ERR_EN
         cnt_q       <= '0;
         err_acc_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         arvalid_q   <= arvalid_d;
         araddr_q    <= araddr_d;
         len_q       <= len_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_last_q  <= rsp_last_d;
`ifdef AXI4_RD_ERR_EN
         cnt_q       <= cnt_d;
         err_acc_q   <= err_acc_d;
         rsp_err_q   <= rsp_err_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign ARVALID  = arvalid_q;
   assign ARADDR   = araddr_q;
   assign ARLEN    = 8'(len_q);
   assign ARID     = ID_W'(ID_VAL);
   assign ARSIZE   = 3'(OFF_W);
   assign ARBURST  = (BURST_WRAP != 0) ? 2'b10 : 2'b01;
   assign ARLOCK   = 1'b0;
   assign ARCACHE  = 4'd0;
   assign ARPROT   = 3'd0;
   assign ARQOS    = 4'd0;
   assign ARREGION = 4'd0;
   assign RREADY   = rready;

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_last  = rsp_last_q;

`ifdef AXI4_RD_ERR_EN
   assign rsp_err = rsp_err_q;
   logic unused_ok;
   assign unused_ok = ^{RID, RRESP[0]};
`else
   logic unused_ok;
   assign unused_ok = ^{RID, RRESP};
`endif

endmodule

// File: tb/tb_axi4_rd_burst_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_rd_burst_master
//
// Directed bench for axi4_rd_burst_master. Stimulus pushes the expected AR
// fields and response beats into queues; monitors on the falling edge pop and
// compare whenever the DUT presents an AR handshake or a response beat.
// A second instance built with BURST_WRAP=1 runs on the same stimulus.
// -----------------------------------------------------------------------------
module tb_axi4_rd_burst_master;

   typedef struct packed {
      logic [31:0] a;
      logic [7:0]  l;
   } ar_t;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
      logic        e;
   } rsp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_len;
   logic        rsp_valid, rsp_ready, rsp_last;
   logic [31:0] rsp_data;
   logic        ARVALID, ARREADY, ARLOCK;
   logic [31:0] ARADDR;
   logic [3:0]  ARID, ARCACHE, ARQOS, ARREGION;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE, ARPROT;
   logic [1:0]  ARBURST;
   logic        RVALID, RLAST, RREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic [3:0]  RID;
   // wrap instance outputs
   logic        w_req_ready, w_rsp_valid, w_rsp_last, w_ARVALID, w_ARLOCK, w_RREADY;
   logic [31:0] w_rsp_data, w_ARADDR;
   logic [3:0]  w_ARID, w_ARCACHE, w_ARQOS, w_ARREGION;
   logic [7:0]  w_ARLEN;
   logic [2:0]  w_ARSIZE, w_ARPROT;
   logic [1:0]  w_ARBURST;
`ifdef AXI4_RD_ERR_EN
   logic        rsp_err, w_rsp_err;
`endif

   int   n_cmp = 0;
   int   n_bad = 0;
   ar_t  ar_q[$];
   rsp_t rsp_q[$];
   logic [3:0] rdy_pat = 4'b1111;
   int   rdy_idx = 0;

   axi4_rd_burst_master #(.BURST_WRAP(0)) u_dut (
      .ACLK(clk), .ARESETn(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
`ifdef AXI4_RD_ERR_EN
      .rsp_err(rsp_err),
`endif
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
      .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
      .ARQOS(ARQOS), .ARREGION(ARREGION),
      .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID), .RREADY(RREADY)
   );

   axi4_rd_burst_master #(.BURST_WRAP(1)) u_wrap (
      .ACLK(clk), .ARESETn(rst_n),
      .req_valid(req_valid), .req_ready(w_req_ready), .req_addr(req_addr), .req_len(req_len),
      .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(w_rsp_data), .rsp_last(w_rsp_last),
`ifdef AXI4_RD_ERR_EN
      .rsp_err(w_rsp_err),
`endif
      .ARVALID(w_ARVALID), .ARREADY(ARREADY), .ARADDR(w_ARADDR), .ARID(w_ARID), .ARLEN(w_ARLEN),
      .ARSIZE(w_ARSIZE), .ARBURST(w_ARBURST), .ARLOCK(w_ARLOCK), .ARCACHE(w_ARCACHE),
      .ARPROT(w_ARPROT), .ARQOS(w_ARQOS), .ARREGION(w_ARREGION),
      .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID), .RREADY(w_RREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Consumer backpressure follows a repeating 4-entry pattern.
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rsp_ready = rdy_pat[rdy_idx];
         rdy_idx   = (rdy_idx + 1) % 4;
      end
   end

   // AR channel monitor
   always @(negedge clk) begin
      if (rst_n && ARVALID && ARREADY) begin
         if (ar_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ar_extra: got AR addr 0x%0h, expected none", ARADDR);
         end else begin
            ar_t e;
            e = ar_q.pop_front();
            $display("AR   addr=0x%08h len=%0d", ARADDR, ARLEN);
            chk("araddr", ARADDR, e.a);
            chk("arlen", ARLEN, e.l);
            chk("arsize", ARSIZE, 3'd2);
            chk("arburst", ARBURST, 2'b01);
            chk("arid", ARID, 4'd0);
            chk("w_arburst", w_ARBURST, 2'b10);
            chk("w_araddr", w_ARADDR, e.a);
         end
      end
   end

   // Response monitor
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (rsp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_extra: got beat 0x%0h, expected none", rsp_data);
         end else begin
            rsp_t e;
            e = rsp_q.pop_front();
            $display("BEAT data=0x%08h last=%0d", rsp_data, rsp_last);
            chk("rsp_data", rsp_data, e.d);
            chk("rsp_last", rsp_last, e.l);
            chk("w_rsp_data", w_rsp_data, e.d);
`ifdef AXI4_RD_ERR_EN
            if (e.l) chk("rsp_err", rsp_err, e.e);
`endif
         end
      end
      if (rst_n && rsp_valid && !rsp_ready) chk("rready_stall", RREADY, 1'b0);
   end

   // One burst: request, optional AR delay (with early RVALID), then beats
   // 0..last_idx; err_idx marks a beat returned with SLVERR.
   task automatic burst(input logic [31:0] addr, input logic [2:0] len, input int ar_delay,
                        input bit early_r, input logic [31:0] dbase, input int last_idx,
                        input int err_idx, input bit exp_err);
      int   n;
      ar_t  a;
      rsp_t r;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("req_ready_wait", req_ready, 1'b1);
      req_valid = 1'b1;
      req_addr  = addr;
      req_len   = len;
      a.a = addr & 32'hFFFF_FFFC;
      a.l = {5'd0, len};
      ar_q.push_back(a);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int c = 0; c < ar_delay; c++) begin
         chk("ar_hold_valid", ARVALID, 1'b1);
         chk("ar_hold_addr", ARADDR, addr & 32'hFFFF_FFFC);
         if (early_r) begin
            RVALID = 1'b1;
            RDATA  = 32'hDEAD_BEEF;
         end
         chk("addr_rready", RREADY, 1'b0);
         @(posedge clk);
         #1;
      end
      RVALID  = 1'b0;
      ARREADY = 1'b1;
      @(posedge clk);
      #1;
      ARREADY = 1'b0;
      for (int i = 0; i <= last_idx; i++) begin
         RVALID = 1'b1;
         RDATA  = dbase + 32'(i);
         RLAST  = (i == last_idx);
         RRESP  = (i == err_idx) ? 2'b10 : 2'b00;
         n = 0;
         @(negedge clk);
         while (!RREADY && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("rready_wait", RREADY, 1'b1);
         r.d = dbase + 32'(i);
         r.l = (i == last_idx);
         r.e = exp_err;
         rsp_q.push_back(r);
         @(posedge clk);
         #1;
      end
      RVALID = 1'b0;
      RLAST  = 1'b0;
      RRESP  = 2'b00;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1'b0);
      chk({tag, "_arvalid"}, ARVALID, 1'b0);
      chk({tag, "_rready"}, RREADY, 1'b0);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_rsp_last"}, rsp_last, 1'b0);
      chk({tag, "_rsp_data"}, rsp_data, 32'd0);
      chk({tag, "_araddr"}, ARADDR, 32'd0);
      chk({tag, "_arlen"}, ARLEN, 8'd0);
   endtask

   initial begin
      ar_t  a;
      rsp_t r;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
      ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0; RLAST = 1'b0; RID = 4'd3;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single beat, immediate ARREADY/RVALID: first beat visible in cycle 3.
      req_valid = 1'b1; req_addr = 32'h1000_0004; req_len = 3'd0;
      ARREADY = 1'b1; RVALID = 1'b1; RDATA = 32'hA5A5_0001; RLAST = 1'b1;
      a.a = 32'h1000_0004; a.l = 8'd0; ar_q.push_back(a);
      r.d = 32'hA5A5_0001; r.l = 1'b1; r.e = 1'b0; rsp_q.push_back(r);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("t1_c1_arvalid", ARVALID, 1'b1);
      chk("t1_c1_rready", RREADY, 1'b0);
      @(posedge clk);
      #1;
      chk("t1_c2_rready", RREADY, 1'b1);
      chk("t1_c2_rsp_valid", rsp_valid, 1'b0);
      chk("t1_c2_arvalid", ARVALID, 1'b0);
      @(posedge clk);
      #1;
      ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
      chk("t1_c3_rsp_valid", rsp_valid, 1'b1);
      chk("t1_c3_req_ready", req_ready, 1'b1);

      // INCR burst of 8 from an unaligned address.
      burst(32'h2000_0003, 3'd7, 0, 1'b0, 32'h2000_0100, 7, -1, 1'b0);

      // Consumer stalls 1,0,0,1 during a 4-beat burst.
      rdy_pat = 4'b1001;
      burst(32'h3000_0010, 3'd3, 0, 1'b0, 32'h3000_0000, 3, -1, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      rdy_pat = 4'b1111;

      // ARREADY delayed 5 cycles with an early RVALID that must be ignored.
      burst(32'h4000_0020, 3'd1, 5, 1'b1, 32'h4000_0200, 1, -1, 1'b0);

      // WRAP instance: data for 0x8, 0xC, 0x0, 0x4 passes through unchanged.
      burst(32'h0000_0008, 3'd3, 0, 1'b0, 32'h0000_0C08, 3, -1, 1'b0);

      // Error cases: SLVERR on beat 2; early RLAST; missing RLAST.
      burst(32'h6000_0000, 3'd3, 0, 1'b0, 32'h6000_0600, 3, 1, 1'b1);
      burst(32'h6100_0000, 3'd7, 0, 1'b0, 32'h6100_0600, 2, -1, 1'b1);
      burst(32'h6200_0000, 3'd1, 0, 1'b0, 32'h6200_0600, 2, -1, 1'b1);
      burst(32'h6300_0000, 3'd2, 1, 1'b0, 32'h6300_0600, 2, -1, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-burst with one beat held in the response register.
      rdy_pat = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      req_valid = 1'b1; req_addr = 32'h5000_0000; req_len = 3'd3; ARREADY = 1'b1;
      a.a = 32'h5000_0000; a.l = 8'd3; ar_q.push_back(a);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'h5555_0000; RLAST = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rsp_valid", rsp_valid, 1'b1);
      chk("mid_rready", RREADY, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_vals("mid");
      RVALID = 1'b0;
      rst_n = 1'b1;
      rdy_pat = 4'b1111;
      @(posedge clk);
      #1;
      chk("post_rst_req_ready", req_ready, 1'b1);
      burst(32'h7000_0044, 3'd2, 2, 1'b0, 32'h7000_0700, 2, -1, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      chk("ar_q_drained", 32'(ar_q.size()), 32'd0);
      chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
      chk("end_rsp_valid", rsp_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
